// File: rtl/alu_result_fifo_if.sv
// Handshake and status bundle between the ALU result FIFO and its environment.
// The master side drives the upstream results, the consumer ready and the status clear.
interface alu_result_fifo_if #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
);
    logic              i_valid;
    logic [1:0]        i_op;
    logic [WIDTH-1:0]  i_y;
    logic              i_overflow;
    logic              i_err;
    logic              o_ready;
    logic              o_valid;
    logic              i_ready;
    logic [1:0]        o_op;
    logic [WIDTH-1:0]  o_y;
    logic              o_overflow;
    logic              o_err;
    logic [ADDR_W:0]   o_count;
    logic              i_clr_status;
    logic              o_sticky_overflow;
    logic              o_sticky_err;
    logic [CNT_W-1:0]  o_err_cnt;

    modport master (
        output i_valid, i_op, i_y, i_overflow, i_err, i_ready, i_clr_status,
        input  o_ready, o_valid, o_op, o_y, o_overflow, o_err, o_count,
               o_sticky_overflow, o_sticky_err, o_err_cnt
    );

    modport slave (
        input  i_valid, i_op, i_y, i_overflow, i_err, i_ready, i_clr_status,
        output o_ready, o_valid, o_op, o_y, o_overflow, o_err, o_count,
               o_sticky_overflow, o_sticky_err, o_err_cnt
    );
endinterface

// File: rtl/alu_result_fifo.sv
// Show-ahead FIFO capturing ALU results with opcode, plus sticky status flags
// and a saturating error counter covering every accepted entry.
module alu_result_fifo #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    alu_result_fifo_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int ENT_W = 2 + WIDTH + 2;
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ADDR_W:0]   PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [ENT_W-1:0] mem_r [DEPTH];
    logic [ADDR_W:0]  wr_ptr_r;
    logic [ADDR_W:0]  rd_ptr_r;
    logic [ADDR_W:0]  count_s;
    logic             empty_s;
    logic             full_s;
    logic             ready_s;
    logic             push_s;
    logic             pop_s;
    logic [ENT_W-1:0] entry_s;
    logic [ENT_W-1:0] head_s;
    logic             sticky_ovf_r;
    logic             sticky_err_r;
    logic [CNT_W-1:0] err_cnt_r;

    // Occupancy, handshake qualification and head selection from the pointer registers.
    always_comb begin
        count_s = wr_ptr_r - rd_ptr_r;
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]) &&
                  (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);
        ready_s = ~full_s & ~i_rst;
        push_s  = bus.i_valid & ready_s;
        pop_s   = ~empty_s & bus.i_ready;
        entry_s = {bus.i_op, bus.i_y, bus.i_overflow, bus.i_err};
        if (empty_s) begin
            head_s = '0;
        end else begin
            head_s = mem_r[rd_ptr_r[ADDR_W-1:0]];
        end
    end

    // Read/write pointers; the extra MSB separates full from empty.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Entry storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= entry_s;
        end
    end

    // Sticky flags and saturating error count; a push on a clearing edge still counts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sticky_ovf_r <= 1'b0;
            sticky_err_r <= 1'b0;
            err_cnt_r    <= '0;
        end else if (bus.i_clr_status) begin
            sticky_ovf_r <= push_s & bus.i_overflow;
            sticky_err_r <= push_s & bus.i_err;
            err_cnt_r    <= (push_s & bus.i_err) ? CNT_ONE : '0;
        end else if (push_s) begin
            sticky_ovf_r <= sticky_ovf_r | bus.i_overflow;
            sticky_err_r <= sticky_err_r | bus.i_err;
            if (bus.i_err && (err_cnt_r != CNT_MAX)) begin
                err_cnt_r <= err_cnt_r + CNT_ONE;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end else begin
            sticky_ovf_r <= sticky_ovf_r;
            sticky_err_r <= sticky_err_r;
            err_cnt_r    <= err_cnt_r;
        end
    end

    assign bus.o_ready           = ready_s;
    assign bus.o_valid           = ~empty_s;
    assign bus.o_count           = count_s;
    assign bus.o_op              = head_s[ENT_W-1 -: 2];
    assign bus.o_y               = head_s[WIDTH+1:2];
    assign bus.o_overflow        = head_s[1];
    assign bus.o_err             = head_s[0];
    assign bus.o_sticky_overflow = sticky_ovf_r;
    assign bus.o_sticky_err      = sticky_err_r;
    assign bus.o_err_cnt         = err_cnt_r;
endmodule
